// File: rtl/pwm_sequencer_pkg.sv
// Shared definitions for the PWM sequencer: default counter width, FSM
// state encodings, mode encodings and a small state-class helper.
package pwm_sequencer_pkg;

  localparam int PWM_N = 8;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOAD     = 2'd1;
  localparam logic [1:0] RUN_UP   = 2'd2;
  localparam logic [1:0] RUN_DOWN = 2'd3;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  function automatic logic is_run(input logic [1:0] s);
    return (s == RUN_UP) || (s == RUN_DOWN);
  endfunction

endpackage

// File: rtl/pwm_sequencer_if.sv
// Host configuration bus of the PWM sequencer.
//   in_cfg_wr    : 1-cycle strobe, capture period/duty/mode into the shadow
//   in_period    : period value P (top count)
//   in_duty      : duty compare value D
//   in_mode      : 0 = edge-aligned, 1 = center-aligned
//   out_cfg_pend : shadow holds values not yet applied
// master = host side, slave = sequencer side.
interface pwm_sequencer_if
  import pwm_sequencer_pkg::*;
#(
  parameter int N = PWM_N
);
  logic         in_cfg_wr;
  logic [N-1:0] in_period;
  logic [N-1:0] in_duty;
  logic         in_mode;
  logic         out_cfg_pend;

  modport master (
    output in_cfg_wr, in_period, in_duty, in_mode,
    input  out_cfg_pend
  );

  modport slave (
    input  in_cfg_wr, in_period, in_duty, in_mode,
    output out_cfg_pend
  );
endinterface

// File: rtl/pwm_sequencer_counter.sv
// n_bit_counter: count datapath of the PWM sequencer.
//   in_clk             : system clock, rising edge
//   in_res             : synchronous active-high reset, clears the count
//   in_input           : value loaded when in_latch is high
//   in_latch           : load in_input (has priority over counting)
//   in_count_en        : step the count this cycle
//   in_count_direction : 1 = increment, 0 = decrement
//   out_output         : registered count
//   out_next           : value out_output takes on the next edge (no reset term)
module n_bit_counter
  import pwm_sequencer_pkg::*;
#(
  parameter int N = PWM_N
) (
  input  logic         in_clk,
  input  logic         in_res,
  input  logic [N-1:0] in_input,
  input  logic         in_latch,
  input  logic         in_count_en,
  input  logic         in_count_direction,
  output logic [N-1:0] out_output,
  output logic [N-1:0] out_next
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_comb begin
    out_next = out_output;
    if (in_latch) begin
      out_next = in_input;
    end else if (in_count_en) begin
      out_next = in_count_direction ? (out_output + ONE) : (out_output - ONE);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_res) begin
      out_output <= '0;
    end else begin
      out_output <= out_next;
    end
  end
endmodule

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: single-channel PWM generator with edge-aligned (sawtooth)
// and center-aligned (triangle) modes. Period/duty/mode writes land in a
// shadow set and only become active at LOAD or at a period boundary.
//   in_clk          : system clock, rising edge
//   in_res          : synchronous active-high reset
//   in_enable       : 1 = run, 0 = stop at the end of the current period
//   cfg             : host configuration bus (slave side)
//   out_count       : registered counter value
//   out_count_dir   : 1 while counting up
//   out_pwm         : registered PWM output, (out_count < active duty) in RUN
//   out_period_strt : high on each RUN cycle with out_count == 0
//   out_busy        : high while the FSM is not IDLE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | stopped, count held at 0, pwm low
// LOAD     | one cycle: shadow -> active, pend cleared, count loaded 0
// RUN_UP   | counting 0..P
// RUN_DOWN | center mode only, counting P-1..1
module pwm_sequencer
  import pwm_sequencer_pkg::*;
#(
  parameter int n = PWM_N
) (
  input  logic          in_clk,
  input  logic          in_res,
  input  logic          in_enable,
  pwm_sequencer_if.slave cfg,
  output logic [n-1:0]  out_count,
  output logic          out_count_dir,
  output logic          out_pwm,
  output logic          out_period_strt,
  output logic          out_busy
);
  localparam logic [n-1:0] CNT_ZERO = '0;
  localparam logic [n-1:0] CNT_ONE  = {{(n-1){1'b0}}, 1'b1};

  logic [1:0]   state, state_nxt;
  logic [n-1:0] count_nxt;
  logic [n-1:0] shadow_p, shadow_d, act_p, act_d, act_d_nxt;
  logic         shadow_m, act_m, pend;
  logic         at_top, center_turn, boundary, apply_cfg;
  logic         cnt_latch, cnt_en, cnt_dir;

  // Center mode with P < 2 has no down leg, so it wraps straight to 0 like
  // edge mode (P == 0 sticks at 0, P == 1 gives 0,1,0,1...).
  assign at_top      = (state == RUN_UP) && (out_count == act_p);
  assign center_turn = at_top && (act_m == MODE_CENTER) && (act_p > CNT_ONE);
  assign boundary    = (at_top && !center_turn) ||
                       ((state == RUN_DOWN) && (out_count == CNT_ONE));
  assign apply_cfg   = (state == LOAD) || (boundary && pend);
  assign act_d_nxt   = apply_cfg ? shadow_d : act_d;

  always_comb begin
    state_nxt = state;
    cnt_latch = 1'b0;
    cnt_en    = 1'b0;
    cnt_dir   = 1'b0;
    case (state)
      IDLE: begin
        if (in_enable) state_nxt = LOAD;
      end
      LOAD: begin
        cnt_latch = 1'b1;
        state_nxt = RUN_UP;
      end
      RUN_UP: begin
        if (boundary) begin
          cnt_latch = 1'b1;
          state_nxt = in_enable ? RUN_UP : IDLE;
        end else if (center_turn) begin
          cnt_en    = 1'b1;
          state_nxt = RUN_DOWN;
        end else begin
          cnt_en  = 1'b1;
          cnt_dir = 1'b1;
        end
      end
      RUN_DOWN: begin
        if (boundary) begin
          cnt_latch = 1'b1;
          state_nxt = in_enable ? RUN_UP : IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  n_bit_counter #(.N(n)) u_counter (
    .in_clk             (in_clk),
    .in_res             (in_res),
    .in_input           (CNT_ZERO),
    .in_latch           (cnt_latch),
    .in_count_en        (cnt_en),
    .in_count_direction (cnt_dir),
    .out_output         (out_count),
    .out_next           (count_nxt)
  );

  // pwm is registered from next-cycle count and duty so it stays aligned
  // with out_count.
  always_ff @(posedge in_clk) begin
    if (in_res) begin
      state   <= IDLE;
      out_pwm <= 1'b0;
    end else begin
      state   <= state_nxt;
      out_pwm <= is_run(state_nxt) && (count_nxt < act_d_nxt);
    end
  end

  // A write on the same edge as an apply lands after it: the boundary takes
  // the old shadow and the new values stay pending for the next boundary.
  always_ff @(posedge in_clk) begin
    if (in_res) begin
      shadow_p <= '0;
      shadow_d <= '0;
      shadow_m <= MODE_EDGE;
      act_p    <= '0;
      act_d    <= '0;
      act_m    <= MODE_EDGE;
      pend     <= 1'b0;
    end else begin
      if (apply_cfg) begin
        act_p <= shadow_p;
        act_d <= shadow_d;
        act_m <= shadow_m;
        pend  <= 1'b0;
      end
      if (cfg.in_cfg_wr) begin
        shadow_p <= cfg.in_period;
        shadow_d <= cfg.in_duty;
        shadow_m <= cfg.in_mode;
        pend     <= 1'b1;
      end
    end
  end

  assign cfg.out_cfg_pend = pend;
  assign out_count_dir    = (state == RUN_UP);
  assign out_period_strt  = is_run(state) && (out_count == CNT_ZERO);
  assign out_busy         = (state != IDLE);
endmodule
